pusch_pingpong_buf: RTL and testbench

Parametrised dual-bank (ping-pong) symbol buffer between the modulation mapper and the transform-precoding FFT in the PUSCH chain. It generalises the per-rail modulator memory into one block carrying NUM_CH packed sample lanes (I and Q by default). The block accepts one symbol of addressed writes per bank and streams a full bank out in address order over a valid/ready handshake while the other bank fills. Overflow, meaning a write into a bank the reader has not released, is detected.

---
 rtl/pusch_pingpong_buf.sv | 192 +++++++++++++++++++
 tb/tb_pusch_pingpong_buf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pusch_pingpong_buf.sv
// ---------------------------------------------------------------------------
// pusch_pingpong_buf
//   Dual-bank symbol buffer between the PUSCH modulation mapper and the
//   transform-precoding FFT. Each bank takes one symbol of addressed
//   writes. A committed bank streams out in address order over a
//   valid/ready handshake while the other bank fills.
//
//   Optional build macro: PINGPONG_OVF_EN
//     When defined, dropped writes set a sticky overflow flag and bump a
//     saturating 8-bit drop counter. When undefined, both outputs are tied
//     to 0. The data path is identical in both builds.
//
// Ports
//   clk_i        single clock, rising edge
//   reset_i      synchronous, active-high
//   wr_en_i      write strobe
//   wr_addr_i    sample index within the current write bank
//   wr_data_i    NUM_CH packed lane samples (lane 0 in LSBs)
//   wr_last_i    final sample of the symbol (length = wr_addr_i+1)
//   wr_ready_o   current write bank is free
//   wr_bank_o    bank currently being written
//   rd_valid_o   rd_data_o is valid
//   rd_ready_i   downstream accepts
//   rd_data_o    packed output sample
//   rd_index_o   index of rd_data_o within the symbol
//   rd_last_o    rd_data_o is the final sample of the bank
//   bank_full_o  per-bank committed-but-not-released flags
//   overflow_o   sticky drop flag
//   drop_cnt_o   saturating count of dropped writes
// ---------------------------------------------------------------------------
module pusch_pingpong_buf #(
   parameter int DATA_WIDTH = 18,
   parameter int NUM_CH     = 2,
   parameter int DEPTH      = 1200,
   parameter int ADDR_WIDTH = 11
) (
   input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         wr_en_i,
   input  logic [ADDR_WIDTH-1:0]        wr_addr_i,
   input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data_i,
   input  logic                         wr_last_i,
   output logic                         wr_ready_o,
   output logic                         wr_bank_o,
   output logic                         rd_valid_o,
   input  logic                         rd_ready_i,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data_o,
   output logic [ADDR_WIDTH-1:0]        rd_index_o,
   output logic                         rd_last_o,
   output logic [1:0]                   bank_full_o,
   output logic                         overflow_o,
   output logic [7:0]                   drop_cnt_o
);

   localparam int WW = NUM_CH * DATA_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   logic [WW-1:0]         mem_q [2][DEPTH];
   logic [ADDR_WIDTH-1:0] last_q [2];     // last index per bank (len-1)
   logic [1:0]            bank_full_q, bank_full_d;
   logic                  wr_bank_q;

   state_t                state_q;
   logic                  rd_bank_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic                  rd_valid_q;
   logic [WW-1:0]         rd_data_q;
   logic [ADDR_WIDTH-1:0] rd_index_q;
   logic                  rd_last_q;

   logic wr_ready, addr_ok, wr_acc, commit;
   logic fetch, fetch_last, release_bank;

   // ---------------- write side ----------------
   assign wr_ready = !bank_full_q[wr_bank_q];
   assign addr_ok  = {1'b0, wr_addr_i} < DEPTH_C;
   assign wr_acc   = wr_en_i && wr_ready && addr_ok;
   assign commit   = wr_acc && wr_last_i;

   // Reader hands a bank back once its last sample is accepted downstream.
   assign release_bank = (state_q == DRAIN) && rd_valid_q && rd_ready_i && rd_last_q;

   // Commit and release can never hit the same bank in one cycle: commit
   // needs the bank empty, release needs it full.
   always_comb begin
      bank_full_d = bank_full_q;
      if (commit)       bank_full_d[wr_bank_q] = 1'b1;
      if (release_bank) bank_full_d[rd_bank_q] = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (wr_acc) mem_q[wr_bank_q][wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         bank_full_q <= '0;
         wr_bank_q   <= 1'b0;
         last_q[0]   <= '0;
         last_q[1]   <= '0;
      end else begin
         bank_full_q <= bank_full_d;
         if (commit) begin
            last_q[wr_bank_q] <= wr_addr_i;
            wr_bank_q         <= ~wr_bank_q;
         end
      end
   end

   // ---------------- reader FSM ----------------
   assign fetch      = !rd_valid_q || rd_ready_i;
   assign fetch_last = (rd_ptr_q == last_q[rd_bank_q]);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         rd_bank_q  <= 1'b0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         rd_index_q <= '0;
         rd_last_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bank_full_q[rd_bank_q]) begin
                  rd_ptr_q <= '0;
                  state_q  <= STREAM;
               end
            end
            STREAM: begin
               // Output register only loads on fetch, so a stalled sample
               // stays put until it is taken.
               if (fetch) begin
                  rd_data_q  <= mem_q[rd_bank_q][rd_ptr_q];
                  rd_index_q <= rd_ptr_q;
                  rd_last_q  <= fetch_last;
                  rd_ptr_q   <= rd_ptr_q + ADDR_WIDTH'(1);
                  rd_valid_q <= 1'b1;
                  if (fetch_last) state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (rd_valid_q && rd_ready_i) begin
                  rd_valid_q <= 1'b0;
                  if (rd_last_q) begin
                     rd_bank_q <= ~rd_bank_q;
                     state_q   <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // ---------------- drop logging ----------------
`ifdef PINGPONG_OVF_EN
   logic       drop;
   logic       overflow_q;
   logic [7:0] drop_cnt_q;

   assign drop = wr_en_i && !wr_acc;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else if (drop) begin
         overflow_q <= 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
   end

   assign overflow_o = overflow_q;
   assign drop_cnt_o = drop_cnt_q;
`else
   assign overflow_o = 1'b0;
   assign drop_cnt_o = '0;
`endif

   assign wr_ready_o  = wr_ready;
   assign wr_bank_o   = wr_bank_q;
   assign rd_valid_o  = rd_valid_q;
   assign rd_data_o   = rd_data_q;
   assign rd_index_o  = rd_index_q;
   assign rd_last_o   = rd_last_q;
   assign bank_full_o = bank_full_q;

endmodule

// File: tb/tb_pusch_pingpong_buf.sv
// ---------------------------------------------------------------------------
// tb_pusch_pingpong_buf
//   Directed bench for pusch_pingpong_buf. Inputs change 1 ns after the
//   rising edge; outputs are sampled either there or on the falling edge.
//   A monitor records every handshake and checks that a stalled output
//   holds. Expected sample words come from pat(symbol, index).
// ---------------------------------------------------------------------------
module tb_pusch_pingpong_buf;

   localparam int DW = 18;
   localparam int NC = 2;
   localparam int DEPTH = 1200;
   localparam int AW = 11;
   localparam int WW = DW * NC;
`ifdef PINGPONG_OVF_EN
   localparam bit OVF = 1'b1;
`else
   localparam bit OVF = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [WW-1:0] wr_data = '0;
   logic          wr_last = 1'b0;
   logic          wr_ready, wr_bank, rd_valid, rd_last, overflow;
   logic          rd_ready = 1'b0;
   logic [WW-1:0] rd_data;
   logic [AW-1:0] rd_index;
   logic [1:0]    bank_full;
   logic [7:0]    drop_cnt;

   int errs = 0;
   int checks = 0;
   int cyc = 0;

   typedef struct {
      logic [AW-1:0] idx;
      logic [WW-1:0] dat;
      logic          last;
      int            t;
   } smp_t;
   smp_t q[$];

   pusch_pingpong_buf dut (
      .clk_i(clk), .reset_i(reset),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_last_i(wr_last),
      .wr_ready_o(wr_ready), .wr_bank_o(wr_bank),
      .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
      .rd_index_o(rd_index), .rd_last_o(rd_last), .bank_full_o(bank_full),
      .overflow_o(overflow), .drop_cnt_o(drop_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [WW-1:0] pat(input int s, input int i);
      logic [DW-1:0] a;
      a = DW'(s * 4096 + i);
      return {a, a ^ 18'h2AAAA};
   endfunction

   // Handshake recorder and stall-hold checker.
   logic          stall_q = 1'b0;
   logic [WW-1:0] hd_q;
   logic [AW-1:0] hi_q;
   logic          hl_q;
   always @(negedge clk) begin
      if (!reset && rd_valid) begin
         if (stall_q) begin
            chk("hold_data", rd_data, hd_q);
            chk("hold_idx", rd_index, hi_q);
            chk("hold_last", rd_last, hl_q);
         end
         if (rd_ready) q.push_back('{rd_index, rd_data, rd_last, cyc});
         stall_q <= !rd_ready;
         hd_q    <= rd_data;
         hi_q    <= rd_index;
         hl_q    <= rd_last;
      end else begin
         stall_q <= 1'b0;
      end
   end

   task automatic do_reset();
      reset = 1'b1; wr_en = 1'b0; wr_last = 1'b0; rd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q.delete();
   endtask

   // Writes addr 0..len-1, wr_last on the final one. Returns 1 ns after the
   // edge that sampled the final write.
   task automatic write_sym(input int s, input int len);
      for (int i = 0; i < len; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat(s, i); wr_last = (i == len - 1);
         @(posedge clk); #1;
      end
      wr_en = 1'b0; wr_last = 1'b0;
   endtask

   task automatic wait_q(input int n, input int budget);
      for (int k = 0; k < budget && q.size() < n; k++) @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic check_q(input int s, input int len, input string tag,
                          output int t0, output int t1);
      int nbad;
      smp_t e;
      nbad = 0; t0 = 0; t1 = 0;
      chk({tag, "_count"}, 64'(q.size() >= len), 1);
      for (int i = 0; i < len && q.size() > 0; i++) begin
         e = q.pop_front();
         if (i == 0) t0 = e.t;
         t1 = e.t;
         if (e.idx != AW'(i) || e.dat != pat(s, i) || e.last != (i == len - 1)) nbad++;
      end
      chk({tag, "_seq"}, nbad, 0);
   endtask

   initial begin
      int t0, t1, t2, t3, nlast;
      logic [15:0] bp;

      // ---- reset state ----
      do_reset();
      chk("rst_valid", rd_valid, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_index", rd_index, 0);
      chk("rst_last", rd_last, 0);
      chk("rst_full", bank_full, 0);
      chk("rst_wready", wr_ready, 1);
      chk("rst_wbank", wr_bank, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_drop", drop_cnt, 0);

      // ---- single symbol, latency and throughput ----
      rd_ready = 1'b1;
      write_sym(1, 12);
      chk("lat_e0", rd_valid, 0);
      chk("one_full", bank_full, 2'b01);
      chk("one_wbank", wr_bank, 1);
      @(posedge clk); #1;
      chk("lat_e1", rd_valid, 0);
      @(posedge clk); #1;
      chk("lat_e2", rd_valid, 1);
      chk("lat_idx", rd_index, 0);
      wait_q(12, 60);
      check_q(1, 12, "single", t0, t1);
      chk("single_thru", t1 - t0, 11);
      @(negedge clk);
      chk("single_free", bank_full, 0);
      @(posedge clk); #1;

      // ---- ping-pong 1200 then 600 ----
      do_reset();
      rd_ready = 1'b1;
      write_sym(2, DEPTH);
      chk("pp_wbank1", wr_bank, 1);
      write_sym(3, 600);
      chk("pp_wbank0", wr_bank, 0);
      wait_q(1800, 2500);
      check_q(2, DEPTH, "pp_b0", t0, t1);
      check_q(3, 600, "pp_b1", t2, t3);
      chk("pp_thru", t1 - t0, DEPTH - 1);
      chk("pp_gap", t2 - t1, 3);

      // ---- backpressure ----
      do_reset();
      write_sym(4, 20);
      bp = 16'b1001_1010_0110_0011;
      for (int k = 0; k < 300 && q.size() < 20; k++) begin
         rd_ready = bp[k % 16];
         @(posedge clk); #1;
      end
      rd_ready = 1'b1;
      check_q(4, 20, "bp", t0, t1);

      // ---- overflow: both banks full, three more writes ----
      do_reset();
      write_sym(5, 4);
      write_sym(6, 4);
      chk("ovf_full", bank_full, 2'b11);
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_addr = AW'(i); wr_data = pat(9, i); wr_last = (i == 2);
         @(posedge clk); #1;
      end
      wr_en = 1'b0; wr_last = 1'b0;
      chk("ovf_wready", wr_ready, 0);
      chk("ovf_full2", bank_full, 2'b11);
      chk("ovf_wbank", wr_bank, 0);
      chk("ovf_flag", overflow, OVF ? 1 : 0);
      chk("ovf_cnt", drop_cnt, OVF ? 3 : 0);
      rd_ready = 1'b1;
      wait_q(8, 100);
      check_q(5, 4, "ovf_b0", t0, t1);
      check_q(6, 4, "ovf_b1", t0, t1);

      // ---- out-of-range address with wr_last ----
      repeat (3) @(posedge clk);
      #1;
      chk("oor_pre", bank_full, 0);
      wr_en = 1'b1; wr_addr = AW'(DEPTH); wr_data = pat(10, 0); wr_last = 1'b1;
      @(posedge clk); #1;
      wr_en = 1'b0; wr_last = 1'b0;
      chk("oor_full", bank_full, 0);
      chk("oor_wbank", wr_bank, 0);
      chk("oor_cnt", drop_cnt, OVF ? 4 : 0);
      chk("oor_flag", overflow, OVF ? 1 : 0);
      repeat (4) @(posedge clk);
      #1;
      chk("oor_nostream", rd_valid, 0);

      // ---- reset mid-stream ----
      do_reset();
      rd_ready = 1'b1;
      write_sym(7, 12);
      wait_q(5, 60);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_valid", rd_valid, 0);
      chk("mid_full", bank_full, 0);
      chk("mid_wready", wr_ready, 1);
      reset = 1'b0;
      nlast = 0;
      foreach (q[i]) if (q[i].last) nlast++;
      chk("mid_nolast", nlast, 0);
      q.delete();
      write_sym(8, 12);
      wait_q(12, 60);
      check_q(8, 12, "mid_fresh", t0, t1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got stuck expected finish");
      $fatal(1);
   end

endmodule
